// File: rtl/sw_pkg.sv
// Shared types and arithmetic helpers for the Smith-Waterman PE array.
// Provides base encodings, the PE state enum, width-aware saturating
// add/floor-at-zero subtract, and small max helpers. The helpers work on a
// 32-bit carrier; callers pass their score width so saturation lands at
// 2^w-1.
package sw_pkg;

    localparam int unsigned MAX_W = 32;
    localparam int unsigned EXT_W = MAX_W + 1;

    typedef enum logic [1:0] {
        BASE_A = 2'b00,
        BASE_T = 2'b01,
        BASE_G = 2'b10,
        BASE_C = 2'b11
    } base_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2
    } pe_state_e;

    typedef logic [MAX_W-1:0] wide_t;

    // a + b, clamped to 2^w - 1
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
        logic [EXT_W-1:0] sum;
        logic [EXT_W-1:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (EXT_W'(1) << w) - EXT_W'(1);
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

    // a - b, floored at 0
    function automatic wide_t sat_sub(input wide_t a, input wide_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic wide_t max2(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic wide_t max3(input wide_t a, input wide_t b, input wide_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic wide_t max4(input wide_t a, input wide_t b, input wide_t c, input wide_t d);
        return max2(max2(a, b), max2(c, d));
    endfunction

endpackage

// File: rtl/sw_cell_calc.sv
// Combinational affine-gap cell datapath.
// Ports: read_base/ref_base - bases being compared; restart - first column,
// treat left/diag context as zero; h_left/e_left/diag - context from the
// previous column of this row; h_up/f_up - H and F from the row above;
// match/mismatch/gap_open/gap_ext - scoring constants; h_c/e_c/f_c - cell
// results.
module sw_cell_calc
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned SC_W    = 4
) (
    input  logic [1:0]         read_base,
    input  logic [1:0]         ref_base,
    input  logic               restart,
    input  logic [SCORE_W-1:0] h_left,
    input  logic [SCORE_W-1:0] e_left,
    input  logic [SCORE_W-1:0] diag,
    input  logic [SCORE_W-1:0] h_up,
    input  logic [SCORE_W-1:0] f_up,
    input  logic [SC_W-1:0]    match,
    input  logic [SC_W-1:0]    mismatch,
    input  logic [SC_W-1:0]    gap_open,
    input  logic [SC_W-1:0]    gap_ext,
    output logic [SCORE_W-1:0] h_c,
    output logic [SCORE_W-1:0] e_c,
    output logic [SCORE_W-1:0] f_c
);

    logic  is_match;
    wide_t hl_w, el_w, dg_w, hu_w, fu_w;
    wide_t go_w, ge_w, sc_w;
    wide_t e_w, f_w, d_w;

    // Left and diagonal context is cleared on the first column of a row.
    assign hl_w = restart ? '0 : MAX_W'(h_left);
    assign el_w = restart ? '0 : MAX_W'(e_left);
    assign dg_w = restart ? '0 : MAX_W'(diag);
    assign hu_w = MAX_W'(h_up);
    assign fu_w = MAX_W'(f_up);
    assign go_w = MAX_W'(gap_open);
    assign ge_w = MAX_W'(gap_ext);

    assign is_match = (read_base == ref_base);
    assign sc_w     = is_match ? MAX_W'(match) : MAX_W'(mismatch);

    // Horizontal gap, vertical gap, then diagonal move.
    assign e_w = max2(sat_sub(hl_w, go_w), sat_sub(el_w, ge_w));
    assign f_w = max2(sat_sub(hu_w, go_w), sat_sub(fu_w, ge_w));
    assign d_w = is_match ? sat_add(dg_w, sc_w, SCORE_W) : sat_sub(dg_w, sc_w);

    assign h_c = SCORE_W'(max4(MAX_W'(0), d_w, e_w, f_w));
    assign e_c = SCORE_W'(e_w);
    assign f_c = SCORE_W'(f_w);

endmodule

// File: rtl/sw_pe_affine.sv
// Smith-Waterman processing element with affine gap scoring.
// Holds one read base and scores one matrix cell per streamed reference base,
// forwarding the stream, H and F to the next PE one cycle later. An unloaded
// (or idle, between alignments) PE passes h/f through unchanged.
// Ports: clk/rst - clock, async active-high reset; load_i/read_2_i - capture
// read base; en_i/sof_i/eof_i/ref_2_i/h_i/f_i - upstream stream beat;
// match/mismatch/gap_open/gap_ext - scoring constants; en_o/sof_o/eof_o/
// ref_2_o/h_o/f_o - downstream stream; max_o/max_col_o - row maximum and its
// column; done_o - pulse after an alignment's last column.
module sw_pe_affine
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned POS_W   = 10,
    parameter int unsigned SC_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [1:0]         read_2_i,
    input  logic               en_i,
    input  logic               sof_i,
    input  logic               eof_i,
    input  logic [1:0]         ref_2_i,
    input  logic [SCORE_W-1:0] h_i,
    input  logic [SCORE_W-1:0] f_i,
    input  logic [SC_W-1:0]    match,
    input  logic [SC_W-1:0]    mismatch,
    input  logic [SC_W-1:0]    gap_open,
    input  logic [SC_W-1:0]    gap_ext,
    output logic               en_o,
    output logic               sof_o,
    output logic               eof_o,
    output logic [1:0]         ref_2_o,
    output logic [SCORE_W-1:0] h_o,
    output logic [SCORE_W-1:0] f_o,
    output logic [SCORE_W-1:0] max_o,
    output logic [POS_W-1:0]   max_col_o,
    output logic               done_o
);

    pe_state_e          state_q, state_d;
    base_e              base_q;
    logic [SCORE_W-1:0] h_left_q, e_left_q, diag_q;
    logic [POS_W-1:0]   col_q;
    logic [POS_W-1:0]   col_cur, col_nxt;
    logic [SCORE_W-1:0] h_c, e_c, f_c;
    logic               compute_c;
    logic               base_load_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a sof+eof beat is a complete one-column alignment.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (load_i) state_d = ST_READY;
            ST_READY: if (en_i && sof_i && !eof_i) state_d = ST_RUN;
            ST_RUN:   if (en_i && eof_i) state_d = ST_READY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Per-state control: score this beat, or accept a new read base.
    always_comb begin
        compute_c   = 1'b0;
        base_load_c = 1'b0;
        unique case (state_q)
            ST_EMPTY: base_load_c = load_i;
            ST_READY: begin
                base_load_c = load_i;
                compute_c   = en_i && sof_i;
            end
            ST_RUN:   compute_c = en_i;
            default: ;
        endcase
    end

    // Column of this beat, and the saturating next column.
    assign col_cur = sof_i ? '0 : col_q;
    assign col_nxt = (&col_cur) ? col_cur : col_cur + POS_W'(1);

    sw_cell_calc #(
        .SCORE_W (SCORE_W),
        .SC_W    (SC_W)
    ) u_cell (
        .read_base (base_q),
        .ref_base  (ref_2_i),
        .restart   (sof_i),
        .h_left    (h_left_q),
        .e_left    (e_left_q),
        .diag      (diag_q),
        .h_up      (h_i),
        .f_up      (f_i),
        .match     (match),
        .mismatch  (mismatch),
        .gap_open  (gap_open),
        .gap_ext   (gap_ext),
        .h_c       (h_c),
        .e_c       (e_c),
        .f_c       (f_c)
    );

    // Stream outputs, row context and maximum tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= BASE_A;
            h_left_q  <= '0;
            e_left_q  <= '0;
            diag_q    <= '0;
            col_q     <= '0;
            en_o      <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            ref_2_o   <= '0;
            h_o       <= '0;
            f_o       <= '0;
            max_o     <= '0;
            max_col_o <= '0;
            done_o    <= 1'b0;
        end else begin
            en_o   <= en_i;
            sof_o  <= en_i & sof_i;
            eof_o  <= en_i & eof_i;
            done_o <= compute_c & eof_i;
            if (base_load_c) begin
                base_q <= base_e'(read_2_i);
            end
            if (en_i) begin
                ref_2_o <= ref_2_i;
                if (compute_c) begin
                    h_o      <= h_c;
                    f_o      <= f_c;
                    h_left_q <= h_c;
                    e_left_q <= e_c;
                    diag_q   <= h_i;
                    col_q    <= col_nxt;
                    // Strict compare keeps the earliest column on ties.
                    if (sof_i || (h_c > max_o)) begin
                        max_o     <= h_c;
                        max_col_o <= col_cur;
                    end
                end else begin
                    h_o <= h_i;
                    f_o <= f_i;
                end
            end
        end
    end

endmodule
